// File: rtl/simple_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : simple_uart_tx_pkg
// Description : Shared types and constants for the 8N1 UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package simple_uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    localparam int FRAME_BITS = 10;

    // Baud divider rounded to the nearest whole clock count.
    function automatic int calc_div(input longint clk_hz, input longint baud);
        return int'((clk_hz + baud / 2) / baud);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : tick_divider
// Description : Free-running modulo-DIV counter emitting a one-cycle tick at
//               count DIV-1. clr holds the count at zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             c_W    = $clog2(DIV);
    localparam logic [c_W-1:0] c_LAST = c_W'(DIV - 1);

    logic [c_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + 1'b1;
        end
    end

    assign tick = en && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/simple_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : simple_uart_tx
// Description : Transmit-only 8N1 UART with internal baud divider. Define
//               SIMPLE_UART_TX_TIMER_EN to add the periodic timer_tick output.
// Revision    : 1.0 - initial release
// ============================================================================
module simple_uart_tx
    import simple_uart_tx_pkg::*;
#(
    parameter int CLK_HZ    = 24_000_000,
    parameter int BAUD      = 115_200,
    parameter int TIMER_DIV = 2_400_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       start,
    output logic       busy,
    output logic       line
`ifdef SIMPLE_UART_TX_TIMER_EN
    ,
    output logic       timer_tick
`endif
);

    localparam int         c_DIV      = calc_div(CLK_HZ, BAUD);
    localparam logic [2:0] c_LAST_BIT = 3'(FRAME_BITS - 3);

    if (c_DIV < 2) begin : g_div_check
        $error("simple_uart_tx: CLK_HZ/BAUD must round to at least 2");
    end

    state_t     r_state,   w_state_nxt;
    logic [7:0] r_shift,   w_shift_nxt;
    logic [2:0] r_bit_idx, w_bit_idx_nxt;
    logic       w_baud_tick;

    // Counter held at zero while idle, so bit timing starts fresh on acceptance.
    tick_divider #(
        .DIV (c_DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (r_state != IDLE),
        .clr   (r_state == IDLE),
        .tick  (w_baud_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_idx <= w_bit_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_idx_nxt = r_bit_idx;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_shift_nxt = data;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_baud_tick) begin
                    w_bit_idx_nxt = '0;
                    w_state_nxt   = DATA;
                end
            end
            DATA: begin
                if (w_baud_tick) begin
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_idx_nxt = r_bit_idx + 3'd1;
                    if (r_bit_idx == c_LAST_BIT) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (w_baud_tick) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);
    assign line = (r_state == START) ? 1'b0 :
                  (r_state == DATA)  ? r_shift[0] : 1'b1;

`ifdef SIMPLE_UART_TX_TIMER_EN
    if (TIMER_DIV < 2) begin : g_timer_div_check
        $error("simple_uart_tx: TIMER_DIV must be at least 2");
    end

    tick_divider #(
        .DIV (TIMER_DIV)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .clr   (1'b0),
        .tick  (timer_tick)
    );
`else
    // Keeps the timer period referenced when the timer is compiled out.
    localparam int c_unused_timer_div = TIMER_DIV;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simple_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_simple_uart_tx
// Description : Self-checking bench for simple_uart_tx (DIV = 10, TIMER_DIV = 50).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_uart_tx;

    localparam int c_DIV = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       start;
    logic       busy;
    logic       line;
`ifdef SIMPLE_UART_TX_TIMER_EN
    logic       timer_tick;
    int         tick_pos[$];
`endif

    int checks   = 0;
    int failures = 0;

    simple_uart_tx #(
        .CLK_HZ    (1000),
        .BAUD      (100),
        .TIMER_DIV (50)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data       (data),
        .start      (start),
        .busy       (busy),
        .line       (line)
`ifdef SIMPLE_UART_TX_TIMER_EN
        ,
        .timer_tick (timer_tick)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Returns the number of sampled cycles until busy is seen (bounded).
    task automatic wait_busy(output int n);
        n = 0;
        while (busy !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Called on the first busy cycle; samples all 10*DIV frame cycles.
    task automatic check_frame(input logic [7:0] d, input bit hold,
                               input bit change, input logic [7:0] new_data,
                               input string tag);
        logic [9:0] exp_f;
        logic [9:0] obs_f;
        int bad_line;
        int bad_busy;
        exp_f    = {1'b1, d, 1'b0};
        obs_f    = '0;
        bad_line = 0;
        bad_busy = 0;
        for (int i = 0; i < 10 * c_DIV; i++) begin
            if (line !== exp_f[i / c_DIV]) bad_line++;
            if (busy !== 1'b1) bad_busy++;
            if (i % c_DIV == c_DIV / 2) obs_f[i / c_DIV] = line;
            if (i == 0 && !hold) start = 1'b0;
            if (i == 50 && change) data = new_data;
            @(negedge clk);
        end
        chk({tag, " bits"}, 32'(obs_f), 32'(exp_f));
        chk({tag, " line_cycles_wrong"}, bad_line, 0);
        chk({tag, " busy_dropouts"}, bad_busy, 0);
        chk({tag, " busy_fall"}, 32'(busy), 0);
    endtask

    task automatic send(input logic [7:0] d, input bit change,
                        input logic [7:0] new_data, input string tag);
        int n;
        data  = d;
        start = 1'b1;
        wait_busy(n);
        chk({tag, " accept_latency"}, n, 1);
        check_frame(d, 1'b0, change, new_data, tag);
    endtask

    initial begin
        int n;
        logic [7:0] d;
        rst_n = 1'b0;
        start = 1'b0;
        data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset line", 32'(line), 1);
        chk("reset busy", 32'(busy), 0);
`ifdef SIMPLE_UART_TX_TIMER_EN
        chk("reset timer_tick", 32'(timer_tick), 0);
`endif
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send(8'h41, 1'b0, 8'h00, "frame41");

        // Back-to-back: start held, data swapped mid-frame for the second byte.
        data  = 8'h42;
        start = 1'b1;
        wait_busy(n);
        chk("b2b first latency", n, 1);
        check_frame(8'h42, 1'b1, 1'b1, 8'h43, "b2b42");
        wait_busy(n);
        chk("b2b gap", n, 1);
        check_frame(8'h43, 1'b0, 1'b0, 8'h00, "b2b43");

        repeat (2) @(negedge clk);
        send(8'h00, 1'b1, 8'hFF, "latch00");

        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(1, 5)) @(negedge clk);
            d = 8'($urandom);
            send(d, 1'b1, 8'($urandom), $sformatf("rand%0d", r));
        end

        // Abort at clock 35 of a frame.
        repeat (2) @(negedge clk);
        data  = 8'h5A;
        start = 1'b1;
        wait_busy(n);
        start = 1'b0;
        repeat (34) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort line", 32'(line), 1);
        chk("abort busy", 32'(busy), 0);
`ifdef SIMPLE_UART_TX_TIMER_EN
        chk("abort timer_tick", 32'(timer_tick), 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-abort idle line", 32'(line), 1);
        send(8'h44, 1'b0, 8'h00, "after_abort44");

`ifdef SIMPLE_UART_TX_TIMER_EN
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 1; j <= 160; j++) begin
            if (j == 20) begin
                data  = 8'hA5;
                start = 1'b1;
            end
            @(negedge clk);
            if (busy) start = 1'b0;
            if (timer_tick === 1'b1) tick_pos.push_back(j);
        end
        chk("timer tick count", tick_pos.size(), 3);
        for (int k = 0; k < 3 && k < tick_pos.size(); k++) begin
            chk($sformatf("timer tick%0d position", k), tick_pos[k], 50 * (k + 1) - 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simple_uart_tx.md
# simple_uart_tx

Transmit-only 8N1 UART with an internal baud-rate divider and an optional periodic timer tick. It sits between a byte-producing controller (for example a string sequencer stepping through a ROM) and the serial output pin. A byte is offered with a level `start` and acknowledged by `busy`. The optional tick paces block-level retransmission.

## Interface
- `CLK_HZ`, default 24_000_000: input clock frequency in Hz.
- `BAUD`, default 115_200: line rate. `DIV = round(CLK_HZ/BAUD)`; elaboration fails if `DIV < 2`.
- `TIMER_DIV`, default 2_400_000: timer tick period in clocks. Only used with `SIMPLE_UART_TX_TIMER_EN`; must be ≥ 2.
- `clk` input 1: single system clock; all logic on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `data` input 8: byte to send; sampled on start acceptance.
- `start` input 1: transmit request, level-sensitive.
- `busy` output 1: high while a frame is in flight.
- `line` output 1: serial TX line; idles high.
- `timer_tick` output 1: one-clock pulse every `TIMER_DIV` clocks. Present only with `SIMPLE_UART_TX_TIMER_EN`.

One clock; reset is asynchronous and active-low.

## Operation
- **Reset values** (while `rst_n` = 0):
  - `line` = 1, `busy` = 0, `timer_tick` = 0.
  - State is IDLE; baud counter, bit index and timer counter are all 0.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** `line` = 1, `busy` = 0. On a clock where `start` = 1:
  - latch `data` into the shift register;
  - clear the baud counter;
  - go to START.
- **START:** `line` = 0 for `DIV` clocks, then go to DATA with bit index 0.
- **DATA:** `line` = `shift[0]`, LSB first, each bit for `DIV` clocks.
  - After each bit: shift right and increment the index.
  - After bit 7: go to STOP.
- **STOP:** `line` = 1 for `DIV` clocks, then go to IDLE.
- **`busy`:** 1 in START, DATA and STOP.
- **Handshake:** the master holds `start` until it sees `busy` = 1, then drops it.
  - If `start` is still 1 when the frame returns to IDLE, the next frame starts on the following clock (back-to-back frames; no extra idle bit beyond the stop bit).
- **Data stability:** changes on `data` or `start` during a frame have no effect on that frame.
- **Baud counter:** width `$clog2(DIV)`; counts 0..`DIV`-1 and wraps. It runs only in non-IDLE states and is reset on acceptance, so bit-0 timing is exact regardless of phase.
- **Mid-operation reset:** a reset during a frame aborts it immediately. `line` returns high and the partial byte is discarded.

## Timing
- Accepting edge N: `busy` = 1 and `line` = 0 from N+1.
- Bit k (start bit = 0, data = 1..8, stop = 9) occupies clocks N+1+k·DIV through N+(k+1)·DIV.
- `busy` falls at N+1+10·DIV.
- Frame length is exactly 10·DIV clocks. The earliest next acceptance is at edge N+10·DIV+1.
- `timer_tick`: the counter runs 0..`TIMER_DIV`-1 continuously from reset; the tick is high on the cycle the counter equals `TIMER_DIV`-1.
  - First tick at clock `TIMER_DIV` after reset release.
  - The tick is independent of the transmitter state.

## Configuration
- **`SIMPLE_UART_TX_TIMER_EN` defined:** the `timer_tick` port, the timer counter and the `TIMER_DIV` check are compiled in.
- **Not defined:** no `timer_tick` port and no timer logic. The transmitter behaviour is identical either way.

## Structure
- **Package `simple_uart_tx_pkg`:**
  - state enum (IDLE, START, DATA, STOP);
  - `FRAME_BITS` = 10;
  - a constant function computing the rounded divider from `CLK_HZ`/`BAUD`.
- **Sub-module `tick_divider`:**
  - parameter `DIV`; inputs `clk`, `rst_n`, `en`, `clr`; output `tick`;
  - one-cycle pulse at count `DIV`-1;
  - instantiated once for the baud rate (gated by FSM state) and once for the timer (`en` tied high, under the macro).

## Test plan
Bench uses `CLK_HZ` = 1000, `BAUD` = 100 (DIV = 10), `TIMER_DIV` = 50.
- **Reset:** assert `rst_n` = 0 mid-stream → `line` = 1, `busy` = 0, `timer_tick` = 0 within the same cycle (asynchronous).
- **Frame:** `data` = 0x41, pulse `start` until `busy` → `line` = 0,1,0,0,0,0,0,1,0,1, each for 10 clocks; `busy` high for exactly 100 clocks.
- **Back-to-back:** hold `start` = 1 with `data` = 0x42 then 0x43 → two frames; the second start bit begins 1 clock after `busy` falls; LSB-first bit patterns match.
- **Latching:** change `data` to 0xFF during a 0x00 frame → all 8 data bits are 0.
- **Abort:** reset at clock 35 of a frame → `line` = 1 immediately; after release, a new 0x44 frame transmits correctly.
- **Timer (macro on):** `timer_tick` pulses at clocks 50, 100, 150 after release, each 1 clock wide, unaffected by a concurrent frame.
